// File: rtl/ntt_pkg.sv
// Shared NTT constants, butterfly mode encodings and scheduler FSM states.
package ntt_pkg;
  localparam int Q      = 12289;
  localparam int DATA_W = 14;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_e;
endpackage

// File: rtl/ntt_bf_delay_line.sv
// Fixed-depth shift register that turns issue-side {valid, addr_u, addr_v}
// into write-back side signals; it shifts every cycle and ignores stalls.
module bf_delay_line #(
  parameter int DEPTH = 6,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH-1:0][W-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/ntt_bf_scheduler.sv
// Address/twiddle scheduler driving one radix-2 butterfly through an in-place
// NTT (CT) or INTT (GS). Optional cycle counter under NTT_SCHED_PERF_EN.
module ntt_bf_scheduler
  import ntt_pkg::*;
#(
  parameter int N    = 256,
  parameter int LOGN = 8,
  parameter int LAT  = 6,
  parameter int AW   = LOGN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic          hold,
`ifdef NTT_SCHED_PERF_EN
  output logic [31:0]   cycle_cnt,
`endif
  output logic          busy,
  output logic          done,
  output logic          sel,
  output logic          issue_valid,
  output logic [AW-1:0] rd_addr_u,
  output logic [AW-1:0] rd_addr_v,
  output logic [AW-1:0] tw_addr,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr_u,
  output logic [AW-1:0] wb_addr_v
);
  localparam int SW = $clog2(LOGN);
  localparam int CW = $clog2(LAT + 1);

  state_e        state, state_nx;
  logic [SW-1:0] stage;
  logic [AW-1:0] j;
  logic [CW-1:0] cnt;
  logic          mode_r;
  logic          last_j, last_stage;

  assign last_j     = (j == AW'(N/2 - 1));
  assign last_stage = (stage == SW'(LOGN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      stage  <= '0;
      j      <= '0;
      cnt    <= '0;
      mode_r <= MODE_NTT;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          mode_r <= mode;
          stage  <= '0;
          j      <= '0;
        end
        S_ISSUE: if (!hold) begin
          if (last_j) begin
            j   <= '0;
            cnt <= CW'(LAT);
          end else begin
            j <= j + AW'(1);
          end
        end
        S_DRAIN: begin
          cnt <= cnt - CW'(1);
          // cnt reaching 0 ends the drain, so the decision is taken at 1
          if (cnt == CW'(1) && !last_stage) stage <= stage + SW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (!hold && last_j) state_nx = S_DRAIN;
      S_DRAIN: if (cnt == CW'(1)) state_nx = last_stage ? S_FIN : S_ISSUE;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);
  assign issue_valid = (state == S_ISSUE) && !hold;
  assign sel         = mode_r;

  // sh = log2(len): NTT halves the span each stage, INTT doubles it
  logic [SW-1:0] sh;
  logic [AW-1:0] len, k, i, u, tw_base;

  always_comb begin
    sh      = (mode_r == MODE_INTT) ? stage : (SW'(LOGN - 1) - stage);
    len     = AW'(1) << sh;
    k       = j >> sh;
    i       = j & (len - AW'(1));
    u       = ((k << sh) << 1) | i;
    tw_base = (mode_r == MODE_INTT) ? (AW'(1) << (SW'(LOGN - 1) - stage))
                                    : (AW'(1) << stage);
    rd_addr_u = '0;
    rd_addr_v = '0;
    tw_addr   = '0;
    if (issue_valid) begin
      rd_addr_u = u;
      rd_addr_v = u | len;
      tw_addr   = tw_base + k;
    end
  end

  bf_delay_line #(.DEPTH(LAT), .W(1 + 2*AW)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({issue_valid, rd_addr_u, rd_addr_v}),
    .dout ({wb_valid, wb_addr_u, wb_addr_v})
  );

`ifdef NTT_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cycle_cnt <= '0;
    else if (state == S_IDLE && start) cycle_cnt <= '0;
    else if (busy)                   cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Self-checking bench for ntt_bf_scheduler at N=8: per-cycle comparison
// against a schedule model built from the transform index arithmetic.
module tb_ntt_bf_scheduler;
  localparam int N = 8, LOGN = 3, LAT = 6, AW = 3;

  logic clk = 0, rst = 1, start = 0, mode = 0, hold = 0;
  logic busy, done, sel, issue_valid, wb_valid;
  logic [AW-1:0] rd_addr_u, rd_addr_v, tw_addr, wb_addr_u, wb_addr_v;
`ifdef NTT_SCHED_PERF_EN
  logic [31:0] cycle_cnt;
`endif

  ntt_bf_scheduler #(.N(N), .LOGN(LOGN), .LAT(LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold),
`ifdef NTT_SCHED_PERF_EN
    .cycle_cnt(cycle_cnt),
`endif
    .busy(busy), .done(done), .sel(sel), .issue_valid(issue_valid),
    .rd_addr_u(rd_addr_u), .rd_addr_v(rd_addr_v), .tw_addr(tw_addr),
    .wb_valid(wb_valid), .wb_addr_u(wb_addr_u), .wb_addr_v(wb_addr_v)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, done, sel, iv;
    logic [AW-1:0] u, v, tw;
    logic wv;
    logic [AW-1:0] wu, wvv;
  } obs_t;

  obs_t obs [256];
  obs_t expo[256];
  bit   hold_arr[256];
  int   n_tests = 0, n_fail = 0;

  // Expected per-cycle outputs: cycle 0 carries start, issues consume
  // non-held cycles, each stage is followed by LAT drain cycles.
  function automatic int build_expected(input bit m);
    int cur, len, k, u, v, tw;
    for (int c = 0; c < 256; c++) expo[c] = '0;
    cur = 1;
    for (int s = 0; s < LOGN; s++) begin
      len = m ? (1 << s) : (N >> (s + 1));
      for (int jj = 0; jj < N/2; jj++) begin
        while (hold_arr[cur]) cur++;
        k  = jj / len;
        u  = 2*len*k + (jj % len);
        v  = u + len;
        tw = m ? ((N >> (s + 1)) + k) : ((1 << s) + k);
        expo[cur].iv = 1'b1;
        expo[cur].u  = AW'(u);
        expo[cur].v  = AW'(v);
        expo[cur].tw = AW'(tw);
        expo[cur+LAT].wv  = 1'b1;
        expo[cur+LAT].wu  = AW'(u);
        expo[cur+LAT].wvv = AW'(v);
        cur++;
      end
      cur += LAT;
    end
    for (int c = 1; c <= cur; c++) begin
      expo[c].busy = 1'b1;
      expo[c].sel  = m;
    end
    expo[cur].done = 1'b1;
    return cur;
  endfunction

  // Drives one run (mode toggles after cycle 0 to show it is not re-sampled)
  task automatic drive_run(input int ncyc, input bit m, input bit restart5);
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (restart5 && c == 5);
      mode  = (c == 0) ? m : ~m;
      hold  = hold_arr[c];
      @(negedge clk);
      obs[c].busy = busy;
      obs[c].done = done;
      obs[c].sel  = busy ? sel : 1'b0;
      obs[c].iv   = issue_valid;
      obs[c].u    = issue_valid ? rd_addr_u : '0;
      obs[c].v    = issue_valid ? rd_addr_v : '0;
      obs[c].tw   = issue_valid ? tw_addr : '0;
      obs[c].wv   = wb_valid;
      obs[c].wu   = wb_valid ? wb_addr_u : '0;
      obs[c].wvv  = wb_valid ? wb_addr_v : '0;
      @(posedge clk); #1;
    end
    start = 0; hold = 0;
  endtask

  task automatic clear_hold();
    for (int c = 0; c < 256; c++) hold_arr[c] = 0;
  endtask

  task automatic test_reset();
    obs_t raw;
    raw = {busy, done, sel, issue_valid, rd_addr_u, rd_addr_v, tw_addr,
           wb_valid, wb_addr_u, wb_addr_v};
    n_tests++;
    if (raw !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", raw);
    end
  endtask

  task automatic test_ntt_plain();
    int dc, nwb;
    clear_hold();
    dc = build_expected(1'b0);
    drive_run(dc + 3, 1'b0, 1'b0);
    nwb = 0;
    for (int c = 0; c < dc + 3; c++) begin
      n_tests++;
      if (obs[c] !== expo[c]) begin
        n_fail++; $display("FAIL ntt_plain cyc=%0d got=%h exp=%h", c, obs[c], expo[c]);
      end
      if (obs[c].wv) nwb++;
    end
    n_tests++;
    if (nwb !== 12) begin n_fail++; $display("FAIL ntt_wb_count got=%0d exp=12", nwb); end
    n_tests++;
    if (obs[31].done !== 1'b1 || obs[30].wv !== 1'b1) begin
      n_fail++; $display("FAIL ntt_done_cycle done31=%b wb30=%b exp=1,1", obs[31].done, obs[30].wv);
    end
    n_tests++;
    if (obs[11].iv !== 1'b1 || obs[11].v !== 3'd2 || obs[11].tw !== 3'd2) begin
      n_fail++; $display("FAIL ntt_stage1_first got=%b/%0d/%0d exp=1/2/2", obs[11].iv, obs[11].v, obs[11].tw);
    end
  endtask

  task automatic test_intt_plain();
    int dc;
    clear_hold();
    dc = build_expected(1'b1);
    drive_run(dc + 3, 1'b1, 1'b0);
    for (int c = 0; c < dc + 3; c++) begin
      n_tests++;
      if (obs[c] !== expo[c]) begin
        n_fail++; $display("FAIL intt_plain cyc=%0d got=%h exp=%h", c, obs[c], expo[c]);
      end
    end
    n_tests++;
    if (obs[1].v !== 3'd1 || obs[1].tw !== 3'd4 || obs[1].sel !== 1'b1) begin
      n_fail++; $display("FAIL intt_first got=%0d/%0d/%b exp=1/4/1", obs[1].v, obs[1].tw, obs[1].sel);
    end
  endtask

  task automatic test_hold();
    int dc;
    clear_hold();
    hold_arr[2] = 1; hold_arr[3] = 1;
    dc = build_expected(1'b0);
    drive_run(dc + 3, 1'b0, 1'b0);
    for (int c = 0; c < dc + 3; c++) begin
      n_tests++;
      if (obs[c] !== expo[c]) begin
        n_fail++; $display("FAIL hold cyc=%0d got=%h exp=%h", c, obs[c], expo[c]);
      end
    end
    n_tests++;
    if (obs[33].done !== 1'b1 || obs[4].u !== 3'd1 || obs[4].v !== 3'd5) begin
      n_fail++; $display("FAIL hold_timing done33=%b pair4=(%0d,%0d) exp=1,(1,5)", obs[33].done, obs[4].u, obs[4].v);
    end
    clear_hold();
  endtask

  task automatic test_restart_ignored();
    int dc;
    clear_hold();
    dc = build_expected(1'b0);
    drive_run(dc + 3, 1'b0, 1'b1);
    for (int c = 0; c < dc + 3; c++) begin
      n_tests++;
      if (obs[c] !== expo[c]) begin
        n_fail++; $display("FAIL restart_ignored cyc=%0d got=%h exp=%h", c, obs[c], expo[c]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    obs_t raw;
    int   bad, dc;
    clear_hold();
    for (int c = 0; c < 12; c++) begin
      start = (c == 0); mode = 1'b0;
      @(posedge clk); #1;
    end
    start = 0;
    rst = 1; #1;
    raw = {busy, done, sel, issue_valid, rd_addr_u, rd_addr_v, tw_addr,
           wb_valid, wb_addr_u, wb_addr_v};
    n_tests++;
    if (raw !== '0) begin n_fail++; $display("FAIL midrun_rst_outputs got=%h exp=0", raw); end
    @(posedge clk); #1; rst = 0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (busy || done || wb_valid || issue_valid) bad++;
    end
    @(posedge clk); #1;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL midrun_rst_quiet got=%0d active cycles exp=0", bad); end
    dc = build_expected(1'b1);
    drive_run(dc + 3, 1'b1, 1'b0);
    for (int c = 0; c < dc + 3; c++) begin
      n_tests++;
      if (obs[c] !== expo[c]) begin
        n_fail++; $display("FAIL post_rst_run cyc=%0d got=%h exp=%h", c, obs[c], expo[c]);
      end
    end
  endtask

  task automatic test_random();
    int dc;
    bit m;
    for (int it = 0; it < 8; it++) begin
      clear_hold();
      for (int c = 1; c < 60; c++) hold_arr[c] = ($urandom_range(0, 3) == 0);
      m  = $urandom_range(0, 1);
      dc = build_expected(m);
      drive_run(dc + 3, m, 1'b0);
      for (int c = 0; c < dc + 3; c++) begin
        n_tests++;
        if (obs[c] !== expo[c]) begin
          n_fail++; $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, c, obs[c], expo[c]);
        end
      end
    end
    clear_hold();
  endtask

  initial begin
    clear_hold();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 0;
    @(posedge clk); #1;
    test_reset();
    test_ntt_plain();
    test_intt_plain();
    test_hold();
    test_restart_ignored();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
